// File: rtl/pc_ras_unit_pkg.sv
// pc_ras_unit_pkg: default sizes and next-PC select encoding shared by the PC/RAS slice
package pc_ras_unit_pkg;
  localparam int ADDR_W_DEF = 64;
  localparam int INST_BYTES_DEF = 4;
  localparam int RAS_DEPTH_DEF = 8;
  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_REDIRECT,
    SEL_HOLD,
    SEL_CALL,
    SEL_RET,
    SEL_SEQ
  } pc_sel_e;
endpackage

// File: rtl/pc_ras_unit_if.sv
// pc_ras_unit_if: fetch control inputs and PC/stack status outputs of the PC/RAS unit
interface pc_ras_unit_if
  import pc_ras_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);
  logic [ADDR_W-1:0] start_pc;
  logic              stall;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              is_call;
  logic [ADDR_W-1:0] call_target;
  logic              is_ret;
  logic [ADDR_W-1:0] current_pc;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_overflow;
  logic              ras_underflow;
  modport master (
    output start_pc, stall, redirect_valid, redirect_pc, is_call, call_target, is_ret,
    input  current_pc, ras_top, ras_empty, ras_full, ras_overflow, ras_underflow
  );
  modport slave (
    input  start_pc, stall, redirect_valid, redirect_pc, is_call, call_target, is_ret,
    output current_pc, ras_top, ras_empty, ras_full, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/pc_ras_unit_ras_stack.sv
// ras_stack: circular LIFO of return addresses; a push when full overwrites the oldest entry
module ras_stack #(
  parameter  int W     = 64,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          replace,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] w_ptr_inc;
  logic          w_empty;
  logic          w_full;
  assign w_ptr_inc = r_ptr + 1'b1;
  assign w_empty   = r_cnt == '0;
  assign w_full    = r_cnt == CW'(DEPTH);
  assign top       = w_empty ? '0 : r_mem[r_ptr];
  assign count     = r_cnt;
  assign overflow  = push & w_full;
  assign underflow = pop & ~push & ~replace & w_empty;
  // r_ptr always addresses the newest entry; wrapping it makes the oldest slot the next victim
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push) begin
      r_ptr            <= w_ptr_inc;
      r_mem[w_ptr_inc] <= push_data;
      if (!w_full) r_cnt <= r_cnt + 1'b1;
    end else if (replace && !w_empty) begin
      r_mem[r_ptr] <= push_data;
    end else if (pop && !w_empty) begin
      r_ptr <= r_ptr - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: fetch PC register with redirect/stall/call/return priority and a return-address stack
module pc_ras_unit
  import pc_ras_unit_pkg::*;
#(
  parameter  int ADDR_W     = ADDR_W_DEF,
  parameter  int INST_BYTES = INST_BYTES_DEF,
  parameter  int RAS_DEPTH  = RAS_DEPTH_DEF,
  localparam int CW         = $clog2(RAS_DEPTH + 1)
) (
  input logic          clk,
  input logic          reset,
  pc_ras_unit_if.slave bus
);
  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_unf;
  pc_sel_e           w_sel;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_top;
  logic [CW-1:0]     w_cnt;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_replace;
  logic              w_ovf;
  logic              w_unf;
  assign w_sel = reset              ? SEL_RESET    :
                 bus.redirect_valid ? SEL_REDIRECT :
                 bus.stall          ? SEL_HOLD     :
                 bus.is_call        ? SEL_CALL     :
                 bus.is_ret         ? SEL_RET      : SEL_SEQ;
  assign w_seq     = r_pc + ADDR_W'(INST_BYTES);
  assign w_empty   = w_cnt == '0;
  // call+ret together overwrites the top in place unless there is nothing to overwrite
  assign w_push    = w_sel == SEL_CALL && (!bus.is_ret || w_empty);
  assign w_replace = w_sel == SEL_CALL && bus.is_ret && !w_empty;
  assign w_pop     = w_sel == SEL_RET;
  assign w_next = w_sel == SEL_REDIRECT ? bus.redirect_pc :
                  w_sel == SEL_HOLD     ? r_pc            :
                  w_sel == SEL_CALL     ? bus.call_target :
                  w_sel == SEL_RET      ? (w_empty ? w_seq : w_top) : w_seq;
  ras_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_stack (
    .clk       (clk),
    .rst       (reset),
    .push      (w_push),
    .pop       (w_pop),
    .replace   (w_replace),
    .push_data (w_seq),
    .top       (w_top),
    .count     (w_cnt),
    .overflow  (w_ovf),
    .underflow (w_unf)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= bus.start_pc;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_pc  <= w_next;
      r_ovf <= r_ovf | w_ovf;
      r_unf <= r_unf | w_unf;
    end
  end
  assign bus.current_pc    = r_pc;
  assign bus.ras_top       = w_top;
  assign bus.ras_empty     = w_empty;
  assign bus.ras_full      = w_cnt == CW'(RAS_DEPTH);
  assign bus.ras_overflow  = r_ovf;
  assign bus.ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: directed and random stimulus checked against a queue-based model of the PC and return stack
module tb_pc_ras_unit;
  localparam int AW = 64;
  localparam int IB = 4;
  localparam int D  = 8;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  pc_ras_unit_if #(.ADDR_W(AW)) bus ();
  pc_ras_unit #(.ADDR_W(AW), .INST_BYTES(IB), .RAS_DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );
  int errors = 0;
  int checks = 0;
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_q[$];
  bit m_ovf;
  bit m_unf;
  task automatic chk(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, "_pc"}, bus.current_pc, m_pc);
    chk({tag, "_top"}, bus.ras_top, m_q.size() > 0 ? m_q[$] : '0);
    chk({tag, "_empty"}, AW'(bus.ras_empty), AW'(m_q.size() == 0));
    chk({tag, "_full"}, AW'(bus.ras_full), AW'(m_q.size() == D));
    chk({tag, "_ovf"}, AW'(bus.ras_overflow), AW'(m_ovf));
    chk({tag, "_unf"}, AW'(bus.ras_underflow), AW'(m_unf));
  endtask
  task automatic cyc(input string tag, input bit r, input bit st, input bit rv, input logic [AW-1:0] rpc,
                     input bit c, input logic [AW-1:0] ct, input bit rt, input logic [AW-1:0] sp);
    reset = r;
    bus.stall = st;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    bus.is_call = c;
    bus.call_target = ct;
    bus.is_ret = rt;
    bus.start_pc = sp;
    @(posedge clk);
    if (r) begin
      m_pc = sp;
      m_q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (rv) begin
      m_pc = rpc;
    end else if (!st) begin
      if (c) begin
        if (rt && m_q.size() > 0) m_q[m_q.size()-1] = m_pc + IB;
        else begin
          if (m_q.size() == D) begin
            void'(m_q.pop_front());
            m_ovf = 1;
          end
          m_q.push_back(m_pc + IB);
        end
        m_pc = ct;
      end else if (rt) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin
          m_pc = m_pc + IB;
          m_unf = 1;
        end
      end else m_pc = m_pc + IB;
    end
    #1;
    chk_all(tag);
  endtask
  task automatic seq(input string tag);
    cyc(tag, 0, 0, 0, '0, 0, '0, 0, '0);
  endtask
  task automatic rst_to(input logic [AW-1:0] sp);
    cyc("reset", 1, 0, 0, '0, 0, '0, 0, sp);
  endtask
  initial begin
    rst_to(64'h1000);
    chk("rst_pc_lit", bus.current_pc, 64'h1000);
    chk("rst_empty_lit", AW'(bus.ras_empty), 1);
    seq("seq1");
    chk("seq1_lit", bus.current_pc, 64'h1004);
    seq("seq2");
    chk("seq2_lit", bus.current_pc, 64'h1008);
    rst_to(64'h1000);
    cyc("call", 0, 0, 0, '0, 1, 64'h2000, 0, '0);
    chk("call_top_lit", bus.ras_top, 64'h1004);
    cyc("ret", 0, 0, 0, '0, 0, '0, 1, '0);
    chk("ret_pc_lit", bus.current_pc, 64'h1004);
    cyc("pre_call", 0, 0, 0, '0, 1, 64'h5000, 0, '0);
    cyc("stall_redir", 0, 1, 1, 64'h3000, 1, 64'h7000, 0, '0);
    chk("redir_lit", bus.current_pc, 64'h3000);
    for (int i = 0; i < 3; i++) cyc("stall", 0, 1, 0, '0, 1, 64'h9000, 1, '0);
    chk("stall_lit", bus.current_pc, 64'h3000);
    rst_to(64'h1000);
    for (int i = 0; i < 9; i++) cyc("ovf_call", 0, 0, 0, '0, 1, 64'h10000 + 64'(i) * 64'h100, 0, '0);
    chk("ovf_lit", AW'(bus.ras_overflow), 1);
    for (int i = 0; i < 8; i++) cyc("ovf_ret", 0, 0, 0, '0, 0, '0, 1, '0);
    chk("last_ret_lit", bus.current_pc, 64'h10004);
    cyc("unf_ret", 0, 0, 0, '0, 0, '0, 1, '0);
    chk("unf_pc_lit", bus.current_pc, 64'h10008);
    chk("unf_lit", AW'(bus.ras_underflow), 1);
    rst_to(64'hFFFF_FFFF_FFFF_FFF8);
    cyc("wrap_call", 0, 0, 0, '0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, '0);
    seq("wrap_seq");
    chk("wrap_lit", bus.current_pc, 64'h0);
    cyc("call_ret", 0, 0, 0, '0, 1, 64'h4000, 1, '0);
    chk("replace_lit", bus.ras_top, 64'h4);
    rst_to(64'h2000);
    cyc("call_ret_empty", 0, 0, 0, '0, 1, 64'h6000, 1, '0);
    for (int i = 0; i < 3000; i++) begin
      cyc("rand", $urandom_range(0, 199) == 0, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 6,
          {$urandom, $urandom}, $urandom_range(0, 99) < 30, {$urandom, $urandom},
          $urandom_range(0, 99) < 30, {$urandom, $urandom});
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 64, as the width of every PC and address bus.
REQ-002 The block SHALL take parameter INST_BYTES, default 4, as the sequential PC increment.
REQ-003 The block SHALL take parameter RAS_DEPTH, default 8, as the number of return-address-stack entries; it must be a power of two and at least 2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start_pc, input, ADDR_W bits: reset vector, sampled only while reset=1.
REQ-007 The block SHALL have port stall, input, 1 bit: hold the PC and the stack.
REQ-008 The block SHALL have port redirect_valid, input, 1 bit: a branch or exception redirect is requested.
REQ-009 The block SHALL have port redirect_pc, input, ADDR_W bits: the redirect target.
REQ-010 The block SHALL have port is_call, input, 1 bit: predecode flag; current_pc holds a call.
REQ-011 The block SHALL have port call_target, input, ADDR_W bits: the call destination.
REQ-012 The block SHALL have port is_ret, input, 1 bit: predecode flag; current_pc holds a return.
REQ-013 The block SHALL have port current_pc, output, ADDR_W bits: the registered fetch PC.
REQ-014 The block SHALL have port ras_top, output, ADDR_W bits: the top stack entry; it is 0 when the stack is empty.
REQ-015 The block SHALL have ports ras_empty and ras_full, outputs, 1 bit each: stack occupancy 0 and RAS_DEPTH respectively.
REQ-016 The block SHALL have port ras_overflow, output, 1 bit: sticky flag, set when a push overwrote an entry.
REQ-017 The block SHALL have port ras_underflow, output, 1 bit: sticky flag, set when a return hit an empty stack.

Function
REQ-018 Per-cycle priority SHALL be: reset, then redirect_valid, then stall, then call/return, then sequential.
REQ-019 When redirect_valid=1, current_pc SHALL become redirect_pc next cycle regardless of stall; the stack is unchanged and is_call/is_ret are ignored.
REQ-020 When stall=1 and there is no redirect, current_pc, the stack and the flags SHALL hold, and is_call/is_ret are ignored.
REQ-021 For a call alone (is_call=1, is_ret=0): push current_pc+INST_BYTES, and current_pc becomes call_target.
REQ-022 For a return alone with a non-empty stack: pop, and current_pc becomes the popped entry.
REQ-023 For a return alone with an empty stack: current_pc becomes current_pc+INST_BYTES, the stack is unchanged, and ras_underflow is set.
REQ-024 For simultaneous is_call and is_ret: if the stack is non-empty, the top entry SHALL be replaced by current_pc+INST_BYTES with occupancy unchanged; if it is empty, this case behaves as a call alone. In both cases current_pc becomes call_target.
REQ-025 With no call, return, stall or redirect, current_pc SHALL become current_pc+INST_BYTES.
REQ-026 All PC arithmetic SHALL be modulo 2^ADDR_W; wrap past all-ones is silent.
REQ-027 The stack SHALL be a circular buffer with a top pointer and a saturating occupancy count (0..RAS_DEPTH).
REQ-028 A push while full SHALL overwrite the oldest entry, keep the count at RAS_DEPTH, and set ras_overflow.
REQ-029 ras_top, ras_empty and ras_full SHALL be combinational from the registered stack state, so they reflect the state after the last edge.
REQ-030 Latency SHALL be one cycle from any input to current_pc; there is no combinational path from inputs to current_pc.

Reset
REQ-031 On a rising clk edge with reset=1: current_pc becomes start_pc, the occupancy count becomes 0, the pointer becomes 0, and ras_overflow and ras_underflow become 0; stack contents are don't-care.
REQ-032 Reset asserted mid-sequence SHALL override redirect, stall, call and return in that cycle.
REQ-033 Outputs after reset SHALL be: ras_empty=1, ras_full=0, ras_top=0.

Structure
REQ-034 The shared package SHALL hold the default ADDR_W, INST_BYTES and RAS_DEPTH values and the next-PC select encoding (RESET, REDIRECT, HOLD, CALL, RET, SEQ).
REQ-035 The stack SHALL be implemented as one sub-module, ras_stack: a parametrised circular LIFO with push, pop and replace controls, count, and overflow/underflow pulses.
REQ-036 The top level SHALL contain only the priority select, the PC register and the sticky flags.

Verification
REQ-037 Reset: reset=1 with start_pc=0x1000, then released -> current_pc 0x1000, then 0x1004, then 0x1008; ras_empty=1.
REQ-038 Call/return: at pc 0x1000, is_call=1, call_target=0x2000 -> pc 0x2000, ras_top 0x1004; is_ret next cycle -> pc 0x1004, ras_empty=1.
REQ-039 Priority: stall=1 and redirect_valid=1 with redirect_pc=0x3000, plus is_call=1 -> pc 0x3000, stack unchanged; stall alone for 3 cycles -> pc held.
REQ-040 Overflow: RAS_DEPTH=8, 9 consecutive calls -> ras_full=1, ras_overflow=1; 8 returns give the 8 newest addresses in LIFO order; a 9th return -> pc+4 and ras_underflow=1.
REQ-041 Wrap: ADDR_W=64, pc=0xFFFF_FFFF_FFFF_FFFC, sequential -> 0x0; call+ret in the same cycle on a non-empty stack -> count unchanged, top replaced.
